blk_transpose_buf: RTL
======================

# blk_transpose_buf

Ping-pong 4x4 transpose buffer between the RDMA read FIFO and the WDMA write FIFO of the DCT accelerator. It consumes row words (4 x 16-bit samples) from the RDMA side, collects a full 4x4 block, and emits the same block as column words on the WDMA side. Two banks let one block fill while the previous one drains, sustaining 1 word/cycle.

## Interface
- DATA_W, 64: word width; 4 samples of DATA_W/4 bits each. Fixed at 64.
- CNT_W, 16: width of the block counter.
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- ap_start  in  1  level; sampled only while idle.
- ap_done  out  1  one-cycle pulse at completion.
- ap_ready  out  1  identical to ap_done.
- ap_idle  out  1  high when no job is active.
- block_cnt  in  CNT_W  number of 4x4 blocks per job; latched at start.
- in_empty_n  in  1  RDMA FIFO has a word (first-word-fall-through).
- in_rd_en  out  1  consume in_data this cycle.
- in_data  in  DATA_W  row word; sample c at bits [16c+15:16c].
- out_full_n  in  1  WDMA FIFO can accept a word.
- out_wr_en  out  1  push out_data this cycle.
- out_data  out  DATA_W  column word; sample r at bits [16r+15:16r].

## Operation
- Idle→Busy: ap_idle=1 and ap_start=1 latches block_cnt. Zeroes blocks_in/blocks_out, wr_bank=rd_bank=0, both bank_full=0. ap_start while busy is ignored.
- block_cnt=0: busy for exactly one cycle with no transfers, then ap_done.
- Fill side:
  - in_rd_en = busy & in_empty_n & !bank_full[wr_bank] & (blocks_in < latched block_cnt).
  - On in_rd_en, store in_data as row wr_row of bank wr_bank, then increment wr_row.
  - After row 3: set bank_full[wr_bank], toggle wr_bank, increment blocks_in.
- Drain side:
  - out_wr_en = busy & bank_full[rd_bank] & out_full_n.
  - out_data = column rd_col of bank rd_bank: {b[3][c], b[2][c], b[1][c], b[0][c]}.
  - On out_wr_en, increment rd_col. After col 3: clear bank_full[rd_bank], toggle rd_bank, increment blocks_out.
- Completion: when blocks_out reaches block_cnt, the job ends. The next cycle has ap_done=ap_ready=1 and ap_idle=1.
- Same-bank set and clear cannot coincide, because wr_bank must be empty before it is written. Set on one bank and clear on the other in the same cycle are both applied.
- out_data is a combinational mux of bank registers. It is valid only when out_wr_en=1.

## Timing
- Reset values:
  - ap_done=0, ap_ready=0, ap_idle=1, in_rd_en=0, out_wr_en=0.
  - Bank registers=0, so out_data=0.
  - All counters and flags=0.
- Reset mid-job: all state returns to reset values in the next cycle and partial block data is discarded. No further in_rd_en or out_wr_en until a new start.
- First in_rd_en: earliest in the cycle after the start cycle.
- Latency: 4th row accepted in cycle N → first column out_wr_en in cycle N+1, given out_full_n=1.
- Throughput: 1 word/cycle on both sides when unstalled. With no stalls, block k+1 rows overlap block k columns.
- Backpressure:
  - out_full_n=0 holds rd_col and the bank with no data loss.
  - If both banks are full, in_rd_en=0 until a bank drains.
- ap_done: asserted in the cycle after the final column's out_wr_en.

## Configuration
- BLK_TRANSPOSE_BYPASS_EN defined:
  - Adds input port bypass (1 bit, latched at start).
  - When bypass=1, out_data outputs row wr-order words unchanged: row r is emitted at slot r.
  - Counters, handshakes and timing are otherwise identical.
- Undefined: the port is absent and the block always transposes.

## Test plan
- Single block:
  - Stimulus: block_cnt=1; rows r carry samples 16'h(r)(c) (e.g. row1 = 0x0013_0012_0011_0010).
  - Required: 4 out words, col0 = 0x0030_0020_0010_0000; ap_done 1 cycle after the 4th write.
- Streaming:
  - Stimulus: block_cnt=3, in_empty_n=1 and out_full_n=1 throughout.
  - Required: 12 in_rd_en and 12 out_wr_en; first out_wr_en 1 cycle after the 4th read; no gaps in either stream.
- Backpressure:
  - Stimulus: block_cnt=2, out_full_n=0 for 10 cycles after the first block fills.
  - Required: in_rd_en stops after 8 reads; output order and values are intact after release.
- Zero blocks:
  - Stimulus: block_cnt=0, start.
  - Required: ap_done pulse 2 cycles after start; in_rd_en and out_wr_en never asserted.
- Reset mid-job:
  - Stimulus: block_cnt=2, assert ap_rst_n=0 after 6 reads.
  - Required: the next cycle has ap_idle=1 and all handshakes 0. A fresh start with block_cnt=1 produces a correct single block.
- Bypass (macro defined):
  - Stimulus: bypass=1, single block.
  - Required: out words equal the input rows in order.

Source files
------------

// File: rtl/blk_transpose_buf_if.sv
// ---------------------------------------------------------------------------
// blk_transpose_buf_if
//
// Purpose: groups the two FIFO-facing sides of the transpose buffer.
//   Read side  (RDMA FIFO, first-word-fall-through):
//     in_empty_n  FIFO holds a word; in_data is that word.
//     in_rd_en    block consumes in_data this cycle.
//     in_data     row word, sample c at bits [16c+15:16c].
//   Write side (WDMA FIFO):
//     out_full_n  FIFO can accept a word.
//     out_wr_en   block pushes out_data this cycle.
//     out_data    column word, sample r at bits [16r+15:16r].
//
// Handshake rule (both sides): a word moves in exactly the cycle where the
// block's enable is high. The block only raises in_rd_en while in_empty_n is
// high and only raises out_wr_en while out_full_n is high, so the enable alone
// marks the transfer. The FIFO-side signals never depend on the enables.
//
// Modports: master = the transpose block, slave = the FIFO pair / bench.
// ---------------------------------------------------------------------------
interface blk_transpose_buf_if #(
    parameter int DATA_W = 64
);
    logic              in_empty_n;
    logic              in_rd_en;
    logic [DATA_W-1:0] in_data;
    logic              out_full_n;
    logic              out_wr_en;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  in_empty_n, in_data, out_full_n,
        output in_rd_en, out_wr_en, out_data
    );

    modport slave (
        output in_empty_n, in_data, out_full_n,
        input  in_rd_en, out_wr_en, out_data
    );
endinterface

// File: rtl/blk_transpose_buf.sv
// ---------------------------------------------------------------------------
// blk_transpose_buf
//
// Purpose: ping-pong 4x4 transpose buffer. Row words (4 x 16-bit samples) are
// read from the RDMA FIFO into one bank while the other bank drains as column
// words to the WDMA FIFO, sustaining one word per cycle on each side.
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst_n     synchronous active-low reset
//   ap_start     job start, sampled only while idle
//   ap_done      one-cycle completion pulse
//   ap_ready     same as ap_done
//   ap_idle      high when no job is active
//   block_cnt    number of 4x4 blocks in the job, latched at start
//   bypass       (only with BLK_TRANSPOSE_BYPASS_EN) emit rows unchanged,
//                latched at start
//   fifo         read/write FIFO handshakes (blk_transpose_buf_if.master)
//   dbg_state_o  control FSM state (0 idle, 1 busy, 2 done)
//
// Optional feature macro: BLK_TRANSPOSE_BYPASS_EN.
// ---------------------------------------------------------------------------
module blk_transpose_buf #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_ready,
    output logic                ap_idle,
    input  logic [CNT_W-1:0]    block_cnt,
`ifdef BLK_TRANSPOSE_BYPASS_EN
    input  logic                bypass,
`endif
    blk_transpose_buf_if.master fifo,
    output logic [1:0]          dbg_state_o
);
    localparam int SW = DATA_W / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  blocks_in_q;
    logic [CNT_W-1:0]  blocks_out_q, blocks_out_d;
    logic [1:0]        wr_row_q, rd_col_q;
    logic              wr_bank_q, rd_bank_q;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [DATA_W-1:0] bank_q [2][4];
`ifdef BLK_TRANSPOSE_BYPASS_EN
    logic              bypass_q;
`endif

    logic busy, start, rd_fire, wr_fire, row_last, col_last;

    always_comb begin
        busy     = (state_q == S_BUSY);
        start    = !busy && ap_start;
        rd_fire  = busy && fifo.in_empty_n && !bank_full_q[wr_bank_q]
                   && (blocks_in_q < cnt_q);
        wr_fire  = busy && bank_full_q[rd_bank_q] && fifo.out_full_n;
        row_last = rd_fire && (wr_row_q == 2'd3);
        col_last = wr_fire && (rd_col_q == 2'd3);
        blocks_out_d = blocks_out_q + CNT_W'(col_last);

        // Set and clear always target different banks: the write bank is
        // empty by construction, the read bank is full.
        bank_full_d = bank_full_q;
        if (row_last) bank_full_d[wr_bank_q] = 1'b1;
        if (col_last) bank_full_d[rd_bank_q] = 1'b0;
    end

    // Control FSM: state register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Control FSM: next state and status outputs. Looking at blocks_out_d
    // (not _q) makes the done cycle follow the final column write directly,
    // and lets a zero-block job leave BUSY after a single cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = ap_start ? S_BUSY : S_IDLE;
            S_BUSY:         if (blocks_out_d == cnt_q) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        ap_done     = (state_q == S_DONE);
        ap_ready    = (state_q == S_DONE);
        ap_idle     = !busy;
        dbg_state_o = state_q;
    end

    // Datapath: job setup, bank fill and drain bookkeeping
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_q        <= '0;
            blocks_in_q  <= '0;
            blocks_out_q <= '0;
            wr_row_q     <= '0;
            rd_col_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_full_q  <= '0;
`ifdef BLK_TRANSPOSE_BYPASS_EN
            bypass_q     <= 1'b0;
`endif
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 4; r++) begin
                    bank_q[b][r] <= '0;
                end
            end
        end else if (start) begin
            cnt_q        <= block_cnt;
            blocks_in_q  <= '0;
            blocks_out_q <= '0;
            wr_row_q     <= '0;
            rd_col_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_full_q  <= '0;
`ifdef BLK_TRANSPOSE_BYPASS_EN
            bypass_q     <= bypass;
`endif
        end else begin
            if (rd_fire) begin
                bank_q[wr_bank_q][wr_row_q] <= fifo.in_data;
                wr_row_q <= wr_row_q + 2'd1;
                if (row_last) begin
                    wr_bank_q   <= ~wr_bank_q;
                    blocks_in_q <= blocks_in_q + CNT_W'(1);
                end
            end
            if (wr_fire) begin
                rd_col_q <= rd_col_q + 2'd1;
                if (col_last) rd_bank_q <= ~rd_bank_q;
            end
            blocks_out_q <= blocks_out_d;
            bank_full_q  <= bank_full_d;
        end
    end

    // Output mux: column rd_col of the read bank, sample r taken from row r.
    always_comb begin
        fifo.in_rd_en  = rd_fire;
        fifo.out_wr_en = wr_fire;
        fifo.out_data  = '0;
`ifdef BLK_TRANSPOSE_BYPASS_EN
        if (bypass_q) begin
            fifo.out_data = bank_q[rd_bank_q][rd_col_q];
        end else begin
            for (int r = 0; r < 4; r++) begin
                fifo.out_data[r*SW +: SW] = bank_q[rd_bank_q][r][rd_col_q*SW +: SW];
            end
        end
`else
        for (int r = 0; r < 4; r++) begin
            fifo.out_data[r*SW +: SW] = bank_q[rd_bank_q][r][rd_col_q*SW +: SW];
        end
`endif
    end
endmodule
